// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one UART transmitter among N_REQ byte sources
module uart_tx_arbiter #(
  parameter int N_REQ = 2,
  parameter int TIMEOUT = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               timeout_err
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOCKED, WAIT_ACK, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] owner, owner_n, ptr, ptr_n, pick;
  logic [WW-1:0] wd, wd_n;
  logic [N_REQ-1:0] grant_n, ready_n;
  logic [7:0] data_n, lane;
  logic last_flag, last_n, start_n, err_n, accept;
  assign lane = req_data[{owner, 3'b000} +: 8];
  assign accept = (state == LOCKED) && req_valid[owner] && !tx_busy;
  // Scan from farthest to nearest so the requester right after ptr wins.
  always_comb begin
    pick = '0;
    for (int o = N_REQ; o >= 1; o--)
      if (req_valid[(int'(ptr) + o) % N_REQ]) pick = IW'((int'(ptr) + o) % N_REQ);
  end
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n = ptr;
    last_n = last_flag;
    wd_n = wd;
    grant_n = grant;
    ready_n = '0;
    data_n = tx_data;
    start_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (|req_valid) begin
        owner_n = pick;
        grant_n = N_REQ'(1) << pick;
        state_n = LOCKED;
      end
      LOCKED: if (accept) begin
        data_n = lane;
        last_n = req_last[owner];
        start_n = 1'b1;
        ready_n = grant;
        wd_n = '0;
        state_n = WAIT_ACK;
      end else if (wd == WW'(TIMEOUT - 1)) begin
        err_n = 1'b1;
        grant_n = '0;
        ptr_n = owner;
        wd_n = '0;
        state_n = IDLE;
      end else if (!req_valid[owner]) begin
        wd_n = wd + 1'b1;
      end
      WAIT_ACK: state_n = tx_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: if (!tx_busy) begin
        state_n = last_flag ? IDLE : LOCKED;
        grant_n = last_flag ? '0 : grant;
        ptr_n = last_flag ? owner : ptr;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr <= IW'(N_REQ - 1);
      last_flag <= 1'b0;
      wd <= '0;
      grant <= '0;
      req_ready <= '0;
      tx_data <= 8'h00;
      tx_start <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
      last_flag <= last_n;
      wd <= wd_n;
      grant <= grant_n;
      req_ready <= ready_n;
      tx_data <= data_n;
      tx_start <= start_n;
      timeout_err <= err_n;
    end
  end
endmodule
